rgb_led_pwm: RTL and testbench
==============================

RGB_LED_PWM -- requirements
Module: rgb_led_pwm

Interface
REQ-001 Parameter PWM_BITS, default 8: width of the PWM counter and of brightness.
REQ-002 Parameter BLINK_DIV, default 25_000_000: clk cycles per blink half-period, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 red, green, blue  input  1 each  colour request from the comparator stage, synchronous to clk.
REQ-006 brightness  input  PWM_BITS  requested duty value.
REQ-007 load  input  1  one-cycle strobe that captures brightness into the pending duty register.
REQ-008 blink_en  input  1  level; enables the blink gating.
REQ-009 led_r, led_g, led_b  output  1 each  PWM-modulated LED drives, active-high.
REQ-010 period_tick  output  1  high for one cycle when the PWM counter equals 2^PWM_BITS-1.

Function
REQ-011 pwm_cnt (PWM_BITS) SHALL free-run, increment every cycle and wrap from 2^PWM_BITS-1 to 0.
REQ-012 The wrap cycle is the cycle in which pwm_cnt = max; period_tick SHALL be 1 only in that cycle.
REQ-013 When load=1, brightness SHALL be written into duty_pend on that edge; later loads overwrite earlier ones.
REQ-014 On each wrap edge, duty_q <= duty_pend and col_q <= {red,green,blue}; no other edge changes duty_q or col_q.
REQ-015 load and wrap in the same cycle: the new brightness goes to duty_pend and the old duty_pend goes to duty_q; the new value is applied at the following wrap.
REQ-016 Colour or brightness changes SHALL first appear on the LEDs at pwm_cnt=0 after the next wrap, so no partial PWM periods occur.
REQ-017 FSM states: IDLE, ON, OFF.
REQ-018 IDLE -> ON on the wrap edge after the first load since reset; the FSM never returns to IDLE except by reset.
REQ-019 In ON with blink_en=1, blink_cnt SHALL increment each cycle; at BLINK_DIV-1 it SHALL clear and the FSM moves to OFF.
REQ-020 In OFF with blink_en=1, blink_cnt SHALL count identically; at BLINK_DIV-1 it SHALL clear and the FSM moves to ON.
REQ-021 blink_en=0: blink_cnt SHALL be held at 0, and OFF -> ON on the next edge.
REQ-022 Blink transitions SHALL be independent of the PWM wrap.
REQ-023 led_x = (state==ON) & col_q[x] & (pwm_cnt < duty_q); decoded only from registers, so the outputs are glitch-free.
REQ-024 duty_q=0 SHALL give a constant 0; duty_q=max SHALL give max/2^PWM_BITS high time and never a constant 1.
REQ-025 The comparison SHALL be unsigned and PWM_BITS wide, with no extension overflow.

Reset
REQ-026 rst=1 SHALL immediately force: pwm_cnt=0, blink_cnt=0, duty_pend=0, duty_q=0, col_q=000, state=IDLE.
REQ-027 With rst=1, led_r/led_g/led_b=0 and period_tick=0, independent of clk.
REQ-028 Reset asserted mid-period or mid-blink SHALL discard the pending load, and the FSM SHALL require a fresh load to leave IDLE.
REQ-029 After rst deasserts, pwm_cnt SHALL start counting from 0 on the first edge.

Verification (PWM_BITS=4, BLINK_DIV=40)
REQ-030 Reset, then drive {r,g,b}=101 with no load for 64 cycles -> all LEDs 0; state IDLE; period_tick every 16 cycles.
REQ-031 load brightness=8 with {r,g,b}=101, blink_en=0 -> from pwm_cnt=0 after the next wrap:
- led_r and led_b are high 8 of every 16 cycles;
- led_g is 0.
REQ-032 brightness=0 and brightness=15 each applied for 3 periods -> LEDs constant 0, then high 15 of 16 cycles.
REQ-033 Change {r,g,b} 110->011 at pwm_cnt=5 -> LED pattern unchanged until the next pwm_cnt=0, then the new colour applies.
REQ-034 load at the wrap cycle with a new value 4 after 12 -> 12 is applied at this wrap and 4 at the next wrap.
REQ-035 blink_en=1 with brightness=15 -> LEDs alternate between 40 cycles PWM-on and 40 cycles 0.
REQ-036 Drop blink_en while in OFF -> ON on the next edge.
REQ-037 Assert rst mid-blink -> outputs drop to 0 asynchronously, and the block stays dark after release until a new load.

Source files
------------

// File: rtl/rgb_led_pwm.sv
// Purpose : RGB LED PWM driver with a double-buffered duty and colour, and an optional blink gate.
// Latency : a load or colour change reaches the LEDs at pwm_cnt=0 after the next counter wrap.
// Backpressure: none; load is a one-cycle strobe and is always accepted.
// Ports   : clk, rst (async, active-high); red/green/blue colour request; brightness + load duty capture;
//           blink_en blink gating level; led_r/led_g/led_b PWM drives; period_tick high when pwm_cnt is at max.
module rgb_led_pwm #(
    parameter int PWM_BITS  = 8,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                red,
    input  logic                green,
    input  logic                blue,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                load,
    input  logic                blink_en,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                period_tick
);

    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_pend;
    logic [PWM_BITS-1:0] duty_q;
    logic [2:0]          col_q;
    logic [BW-1:0]       blink_cnt;
    logic [BW-1:0]       blink_nxt;
    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                armed;
    logic                wrap;
    logic                lit;

    assign wrap = (pwm_cnt == PWM_MAX);

    // Free-running PWM counter; wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // duty_pend is the staging register; duty_q/col_q only move on the wrap edge so every
    // PWM period is built from one consistent duty and colour. A load in the wrap cycle
    // still lands in duty_pend while the previous pending value is promoted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_pend <= '0;
            duty_q    <= '0;
            col_q     <= 3'b000;
            armed     <= 1'b0;
        end else begin
            if (load) begin
                duty_pend <= brightness;
                armed     <= 1'b1;
            end
            if (wrap) begin
                duty_q <= duty_pend;
                col_q  <= {red, green, blue};
            end
        end
    end

    // Blink FSM. armed must already be set when the wrap edge arrives, so a load in the
    // wrap cycle itself enables output one period later (its duty is not active yet anyway).
    always_comb begin
        state_nxt = state;
        blink_nxt = blink_cnt;
        case (state)
            ST_IDLE: begin
                blink_nxt = '0;
                if (wrap && armed) begin
                    state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (blink_en) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_nxt = '0;
                        state_nxt = ST_OFF;
                    end else begin
                        blink_nxt = blink_cnt + 1'b1;
                    end
                end else begin
                    blink_nxt = '0;
                end
            end
            ST_OFF: begin
                if (blink_en) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_nxt = '0;
                        state_nxt = ST_ON;
                    end else begin
                        blink_nxt = blink_cnt + 1'b1;
                    end
                end else begin
                    // Blinking disabled while dark: return to lit immediately.
                    blink_nxt = '0;
                    state_nxt = ST_ON;
                end
            end
            default: begin
                blink_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            blink_cnt <= '0;
        end else begin
            state     <= state_nxt;
            blink_cnt <= blink_nxt;
        end
    end

    // Outputs decode registers only. Strict less-than means duty 0 is always dark and
    // duty max leaves exactly one dark cycle per period.
    assign lit         = (state == ST_ON) && (pwm_cnt < duty_q);
    assign led_r       = lit & col_q[2];
    assign led_g       = lit & col_q[1];
    assign led_b       = lit & col_q[0];
    assign period_tick = wrap;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Purpose : self-checking bench for rgb_led_pwm (PWM_BITS=4, BLINK_DIV=40) with a scoreboard.
// Latency : expected outputs are queued per cycle and compared on the falling edge.
// Backpressure: not applicable; the DUT presents a new output every cycle.
module tb_rgb_led_pwm;

    localparam int PB    = 4;
    localparam int DIV   = 40;
    localparam int NPER  = 1 << PB;

    logic          clk;
    logic          rst;
    logic          red;
    logic          green;
    logic          blue;
    logic [PB-1:0] brightness;
    logic          load;
    logic          blink_en;
    logic          led_r;
    logic          led_g;
    logic          led_b;
    logic          period_tick;

    rgb_led_pwm #(.PWM_BITS(PB), .BLINK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .brightness (brightness),
        .load       (load),
        .blink_en   (blink_en),
        .led_r      (led_r),
        .led_g      (led_g),
        .led_b      (led_b),
        .period_tick(period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: time since reset decides the PWM phase; settings are
    // captured at period boundaries; blink is "cycles spent in current half".
    int   m_cyc;
    int   m_pend;
    int   m_duty;
    logic [2:0] m_col;
    bit   m_armed;
    int   m_mode;   // 0 dark-until-loaded, 1 lit, 2 blinked off
    int   m_half;

    function automatic logic [3:0] model_out();
        int  phase;
        bit  on;
        phase = m_cyc % NPER;
        on    = (m_mode == 1) && (phase < m_duty);
        return {on & m_col[2], on & m_col[1], on & m_col[0], (phase == NPER - 1)};
    endfunction

    task automatic model_reset();
        m_cyc   = 0;
        m_pend  = 0;
        m_duty  = 0;
        m_col   = 3'b000;
        m_armed = 0;
        m_mode  = 0;
        m_half  = 0;
    endtask

    task automatic model_advance(input logic [2:0] c, input int br, input bit ld, input bit ben);
        bit period_end;
        period_end = ((m_cyc % NPER) == NPER - 1);
        case (m_mode)
            0: if (period_end && m_armed) begin m_mode = 1; m_half = 0; end
            1: begin
                if (ben) begin
                    m_half++;
                    if (m_half == DIV) begin m_half = 0; m_mode = 2; end
                end else begin
                    m_half = 0;
                end
            end
            default: begin
                if (ben) begin
                    m_half++;
                    if (m_half == DIV) begin m_half = 0; m_mode = 1; end
                end else begin
                    m_half = 0;
                    m_mode = 1;
                end
            end
        endcase
        if (period_end) begin
            m_duty = m_pend;
            m_col  = c;
        end
        if (ld) begin
            m_pend  = br;
            m_armed = 1;
        end
        m_cyc++;
    endtask

    // Monitor: every cycle is an output sample.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({led_r, led_g, led_b, period_tick} !== e.v) begin
                fails++;
                $display("FAIL leds_tick cyc=%0d got rgb_tick=%b expected %b", e.cyc,
                         {led_r, led_g, led_b, period_tick}, e.v);
            end
        end
    end

    // Called at posedge+1: queue this cycle's expectation, then commit inputs to the model.
    task automatic step();
        exp_t e;
        e.v   = model_out();
        e.cyc = m_cyc;
        exp_q.push_back(e);
        model_advance({red, green, blue}, int'(brightness), load, blink_en);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic until_phase(input int p);
        for (int i = 0; i < NPER && (m_cyc % NPER) != p; i++) step();
    endtask

    task automatic do_load(input int br);
        brightness = PB'(br);
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    task automatic set_col(input logic [2:0] c);
        {red, green, blue} = c;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge occurs.
    task automatic do_reset(input int hold);
        exp_t e;
        rst  = 1'b1;
        load = 1'b0;
        #1;
        tests++;
        if ({led_r, led_g, led_b, period_tick} !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset got rgb_tick=%b expected 0000", {led_r, led_g, led_b, period_tick});
        end
        model_reset();
        for (int i = 0; i < hold; i++) begin
            e.v   = 4'b0000;
            e.cyc = -1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        red        = 1'b0;
        green      = 1'b0;
        blue       = 1'b0;
        brightness = '0;
        load       = 1'b0;
        blink_en   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // Colour requested but never loaded: stays dark, tick every 16.
        set_col(3'b101);
        run(64);

        // Duty 8, red+blue.
        until_phase(6);
        do_load(8);
        run(4 * NPER);

        // Duty extremes.
        do_load(0);
        run(3 * NPER + 4);
        do_load(15);
        run(3 * NPER + 4);

        // Colour change mid-period.
        set_col(3'b110);
        run(2 * NPER);
        until_phase(5);
        set_col(3'b011);
        run(2 * NPER);

        // Load in the wrap cycle: 12 then 4.
        set_col(3'b111);
        until_phase(3);
        do_load(12);
        until_phase(NPER - 1);
        do_load(4);
        run(3 * NPER);

        // Blink at full brightness.
        do_load(15);
        run(NPER);
        blink_en = 1'b1;
        run(200);

        // Drop blink_en while off.
        for (int i = 0; i < 200 && m_mode != 2; i++) step();
        run(5);
        blink_en = 1'b0;
        run(20);

        // Reset mid-blink, then stay dark until a fresh load.
        blink_en = 1'b1;
        run(57);
        do_reset(2);
        run(48);
        do_load(10);
        run(3 * NPER);

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            red        = 1'($urandom_range(0, 1));
            green      = 1'($urandom_range(0, 1));
            blue       = 1'($urandom_range(0, 1));
            brightness = PB'($urandom_range(0, NPER - 1));
            load       = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 399) == 0) do_reset(2);
            step();
        end
        load = 1'b0;

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
